// File: rtl/decoder_rr_arbiter.sv
// ----------------------------------------------------------------------------
// decoder_rr_arbiter
//
// Eight-way round-robin arbiter with a registered grant index and a one-hot
// decoded copy of that index. The search for a winner starts at ptr and
// wraps modulo 8. ptr advances to (last winner + 1) each time a grant ends.
// One idle GAP cycle always separates two consecutive grants.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   defined   - an 8-bit hold counter caps every grant at MAX_HOLD cycles.
//               timeout_pulse marks the last cycle of a force-ended grant.
//   undefined - there is no counter, grants are unbounded and
//               timeout_pulse is tied to 0.
//
// Parameters:
//   MAX_HOLD       maximum GRANT cycles per grant when the timeout is
//                  compiled in (1..255)
//
// Ports:
//   sys_clk        single clock; all state changes on the rising edge
//   sys_rst        asynchronous, active-high reset
//   req[7:0]       level-sensitive request lines, bit i = requester i
//   done[7:0]      release strobes; only the bit of the granted index counts
//   grant_valid    a grant is active this cycle
//   grant_idx[2:0] granted index (bit 2 -> decoder in_1, bit 1 -> in_2,
//                  bit 0 -> in_3); holds its value while no grant is active
//   grant_oh[7:0]  one-hot decode of grant_idx, all zeros when no grant
//   timeout_pulse  one-cycle pulse on the last cycle of a timed-out grant
// ----------------------------------------------------------------------------
module decoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] req,
    input  logic [7:0] done,
    output logic       grant_valid,
    output logic [2:0] grant_idx,
    output logic [7:0] grant_oh,
    output logic       timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [2:0] ptr;
    logic [2:0] ptr_n;
    logic [2:0] idx_n;
    logic [2:0] winner;
    logic       timeout_hit;
    logic       grant_end;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("decoder_rr_arbiter: MAX_HOLD must be within 1..255");
    end

    // Round-robin search. Offsets are scanned from 7 down to 0 so that the
    // smallest offset from ptr (the highest-priority requester) is written last.
    always_comb begin
        winner = ptr;
        for (int k = 7; k >= 0; k--) begin
            if (req[ptr + 3'(k)]) begin
                winner = ptr + 3'(k);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_n;
    logic       timeout_pulse_n;

    assign timeout_hit = (hold_cnt == HOLD_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Only meaningful while in GRANT; done bits of other requesters never count.
    assign grant_end = done[grant_idx] | ~req[grant_idx] | timeout_hit;

    // Next-state logic.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch can be inferred.
    always_comb begin
        state_n = state;
        idx_n   = grant_idx;
        ptr_n   = ptr;
        case (state)
            IDLE, GAP: begin
                if (|req) begin
                    state_n = GRANT;
                    idx_n   = winner;
                end else begin
                    state_n = IDLE;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    state_n = GAP;
                    ptr_n   = grant_idx + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs. The outputs are computed from the next
    // state, so they line up with the state register without any output decode.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples values from before the edge regardless of statement order.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            grant_valid <= 1'b0;
            grant_idx   <= 3'd0;
            grant_oh    <= 8'd0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            grant_valid <= (state_n == GRANT);
            grant_idx   <= idx_n;
            grant_oh    <= (state_n == GRANT) ? (8'd1 << idx_n) : 8'd0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Counter reads 0 on the first GRANT cycle and k on the (k+1)-th. Any
    // cycle spent outside GRANT primes it to restart at 0 on the next entry.
    // The pulse is computed one cycle early so that it can be registered and
    // still coincide with the final GRANT cycle.
    always_comb begin
        hold_cnt_n = hold_cnt + 8'd1;
        if (state != GRANT) begin
            hold_cnt_n = 8'd0;
        end
        timeout_pulse_n = (state_n == GRANT) && (hold_cnt_n == HOLD_LAST);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hold_cnt      <= 8'd0;
            timeout_pulse <= 1'b0;
        end else begin
            hold_cnt      <= hold_cnt_n;
            timeout_pulse <= timeout_pulse_n;
        end
    end
`else
    assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_decoder_rr_arbiter
//
// Directed stimulus with a scoreboard. Each scenario pushes the grants it
// expects (index, length, idle cycles before it, timeout pulse). A monitor
// samples on the falling edge, pops one entry per grant it observes and
// checks index, one-hot, spacing, length, index stability and timeout pulse.
// Inputs are driven 1 time unit after the rising edge. "Cycle k" of a
// scenario is the period that follows the k-th rising edge after the
// scenario begins.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decoder_rr_arbiter;

    localparam int unsigned TB_MAX_HOLD = 6;

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] req;
    logic [7:0] done;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] grant_oh;
    logic       timeout_pulse;

    decoder_rr_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .req           (req),
        .done          (done),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .grant_oh      (grant_oh),
        .timeout_pulse (timeout_pulse)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [2:0] idx;  // expected winner
        int         len;  // expected GRANT cycles seen on falling edges
        int         gap;  // expected idle cycles before the grant, -1 = skip
        logic       tp;   // timeout pulse expected on the last grant cycle
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic push(input logic [2:0] idx, input int len, input int gap,
                        input logic tp);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.gap = gap;
        e.tp  = tp;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    bit         in_grant  = 0;
    bit         has_cur   = 0;
    exp_t       cur;
    int         cur_len   = 0;
    int         idle_cnt  = 0;
    int         tp_cnt    = 0;
    logic       last_tp   = 1'b0;
    logic [2:0] start_idx = 3'd0;
    bit         idx_moved = 0;
    int         idle_bad  = 0;

    always @(negedge sys_clk) begin
        if (grant_valid) begin
            if (!in_grant) begin
                in_grant  = 1;
                cur_len   = 0;
                tp_cnt    = 0;
                idx_moved = 0;
                start_idx = grant_idx;
                check("grant_was_expected", 32'(sb.size() > 0), 32'd1);
                has_cur = (sb.size() > 0);
                if (has_cur) begin
                    cur = sb.pop_front();
                    check("grant_idx", 32'(grant_idx), 32'(cur.idx));
                    check("grant_oh", 32'(grant_oh), 32'(8'd1 << cur.idx));
                    if (cur.gap >= 0)
                        check("idle_before_grant", 32'(idle_cnt), 32'(cur.gap));
                end
            end
            cur_len++;
            if (timeout_pulse) tp_cnt++;
            last_tp = timeout_pulse;
            if (grant_idx != start_idx) idx_moved = 1;
        end else begin
            if (in_grant) begin
                in_grant = 0;
                idle_cnt = 0;
                if (has_cur) begin
                    check("grant_len", 32'(cur_len), 32'(cur.len));
                    check("timeout_pulse_count", 32'(tp_cnt), cur.tp ? 32'd1 : 32'd0);
                    check("timeout_pulse_last", 32'(last_tp), 32'(cur.tp));
                    check("grant_idx_stable", 32'(idx_moved), 32'd0);
                end
            end
            if (grant_oh != 8'd0 || timeout_pulse) idle_bad++;
            idle_cnt = sys_rst ? 0 : idle_cnt + 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        sys_rst = 1'b1;
        req     = 8'h00;
        done    = 8'h00;
        tick(2);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd0);
        check("rst_grant_oh", 32'(grant_oh), 32'd0);
        check("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);

        // Single requester: grant in cycles 1..5 ended by done, GAP in
        // cycle 6, regrant in cycle 7, then ended by dropping req.
        push(3'd0, 5, 1, 1'b0);
        push(3'd0, 2, 1, 1'b0);
        tick(1); sys_rst = 1'b0; req = 8'h01;       // cycle 0
        tick(5); done = 8'h01;                      // cycle 5
        tick(1); done = 8'h00;                      // cycle 6 (GAP)
        tick(2); req = 8'h00;                       // cycle 8
        tick(3);

        // All eight requesting with done held: 0,1,...,7,0 one cycle each.
        sys_rst = 1'b1;
        tick(1);
        for (int i = 0; i < 9; i++) push(3'(i % 8), 1, 1, 1'b0);
        sys_rst = 1'b0; req = 8'hFF; done = 8'hFF;  // cycle 0
        tick(17); req = 8'h00; done = 8'h00;        // cycle 17, last grant
        tick(3);                                    // ptr now 1

        // Grant 5 leaves ptr=6, then req=21 must wrap to 0, not pick 5.
        push(3'd5, 1, -1, 1'b0);
        push(3'd0, 2, 1, 1'b0);
        req = 8'h20;                                // cycle 0
        tick(1); done = 8'h20;                      // cycle 1
        tick(1); done = 8'h00; req = 8'h21;         // cycle 2 (GAP)
        tick(2); done = 8'h01;                      // cycle 4
        tick(1); done = 8'h00; req = 8'h00;         // cycle 5 (GAP)
        tick(3);                                    // ptr now 1

        // Granted 1 ignores done[2]; dropping req[1] ends it; 2 follows.
        push(3'd1, 3, -1, 1'b0);
        push(3'd2, 2, 1, 1'b0);
        req = 8'h06;                                // cycle 0
        tick(1); done = 8'h04;                      // cycle 1
        tick(2); req = 8'h04; done = 8'h00;         // cycle 3
        tick(3); req = 8'h00;                       // cycle 6
        tick(3);                                    // ptr now 3

`ifdef ARB_TIMEOUT_EN
        // Held request with no done: two 6-cycle grants to 2, each with a
        // pulse on its last cycle; done arrives on the second timeout cycle.
        push(3'd2, 6, -1, 1'b1);
        push(3'd2, 6, 1, 1'b1);
        req = 8'h04;                                // cycle 0
        tick(13); req = 8'h00; done = 8'h04;        // cycle 13
        tick(1); done = 8'h00;
        tick(3);
`else
        // Without the timeout a held grant never ends on its own.
        push(3'd2, 20, -1, 1'b0);
        req = 8'h04;                                // cycle 0
        tick(20); req = 8'h00;                      // cycle 20
        tick(3);
`endif
        // ptr now 3

        // Grant 3 twice (ptr becomes 4), reset during the second grant,
        // then req=18 must pick 3 because ptr is back to 0.
        push(3'd3, 1, -1, 1'b0);
        push(3'd3, 2, 1, 1'b0);
        push(3'd3, 2, 1, 1'b0);
        push(3'd4, 1, 1, 1'b0);
        req = 8'h08;                                // cycle 0
        tick(1); done = 8'h08;                      // cycle 1
        tick(1); done = 8'h00;                      // cycle 2 (GAP)
        tick(3); sys_rst = 1'b1;                    // cycle 5, grant cycle 3
        #1;
        check("midgrant_rst_valid", 32'(grant_valid), 32'd0);
        check("midgrant_rst_oh", 32'(grant_oh), 32'd0);
        check("midgrant_rst_idx", 32'(grant_idx), 32'd0);
        check("midgrant_rst_tp", 32'(timeout_pulse), 32'd0);
        tick(1); sys_rst = 1'b0; req = 8'h18;       // cycle 6
        tick(2); done = 8'h08; req = 8'h10;         // cycle 8
        tick(2); done = 8'h00; req = 8'h00;         // cycle 10
        tick(4);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("grant_closed_at_end", 32'(in_grant), 32'd0);
        check("idle_outputs_zero", 32'(idle_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decoder_rr_arbiter.md
DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum GRANT cycles per grant when timeout is compiled in; legal range 1..255.
REQ-002 sys_clk  input  1  single clock; all state updates on rising edge.
REQ-003 sys_rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  8  request lines; bit i is requester i; level-sensitive.
REQ-005 done  input  8  release strobes; bit i, sampled only while i is granted, ends its grant.
REQ-006 grant_valid  output  1  a grant is active this cycle.
REQ-007 grant_idx  output  3  granted requester index; bit 2 drives decoder in_1, bit 1 drives in_2, bit 0 drives in_3.
REQ-008 grant_oh  output  8  one-hot copy of grant_idx, gated by grant_valid; all zeros when grant_valid=0.
REQ-009 timeout_pulse  output  1  one-cycle pulse when a grant is force-ended by the timeout.

Function
REQ-010 FSM states SHALL be IDLE, GRANT and GAP; all outputs SHALL be registered.
REQ-011 IDLE: grant_valid=0; if req!=0, the winner SHALL be chosen and the FSM SHALL enter GRANT on the next edge (1-cycle request-to-grant latency).
REQ-012 Winner SHALL be the first set req bit searching upward from ptr, modulo 8 (ptr=7 searches 7,0,1,...,6).
REQ-013 ptr SHALL reset to 0 and, on every grant end, SHALL load (grant_idx+1) mod 8 (wrap 7->0).
REQ-014 GRANT: grant_valid=1; grant_idx SHALL stay constant for the whole grant regardless of other req changes.
REQ-015 Grant SHALL end when done[grant_idx]=1, or req[grant_idx]=0, or the timeout fires; the FSM then enters GAP.
REQ-016 done bits of non-granted requesters SHALL be ignored.
REQ-017 GAP: grant_valid=0 for exactly one cycle; grant_idx SHALL hold its last value; arbitration SHALL run with the updated ptr; next state is GRANT if req!=0, else IDLE.
REQ-018 A requester that loses SHALL keep its request pending; with all 8 requesting continuously, every index SHALL be granted once per 8 grants.
REQ-019 If done and timeout occur in the same cycle, the grant SHALL end once, and timeout_pulse SHALL assert.
REQ-020 A request asserted and dropped while never granted SHALL produce no grant.

Reset
REQ-021 On sys_rst=1, the block SHALL asynchronously force state=IDLE, ptr=0, hold counter=0, grant_valid=0, grant_idx=0, grant_oh=0 and timeout_pulse=0.
REQ-022 Reset asserted mid-grant SHALL drop grant_valid immediately without completing the grant.
REQ-023 After reset release, the first arbitration SHALL occur on the first rising edge with sys_rst=0.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on GRANT entry and increment each GRANT cycle. When it reaches MAX_HOLD-1 while still in GRANT, the grant SHALL end as in REQ-015 and timeout_pulse SHALL assert for 1 cycle.
REQ-025 Macro ARB_TIMEOUT_EN undefined: there SHALL be no counter, the grant length SHALL be unbounded, and timeout_pulse SHALL be tied to 0.

Verification
REQ-026 Reset, then req=8'h01 from cycle 0 and done[0] at cycle 5 -> grant_valid=1 with grant_idx=0 and grant_oh=8'h01 from cycle 1 to 5; GAP at cycle 6; regrant to 0 at cycle 7.
REQ-027 req=8'hFF held, done pulsed each grant -> grant_idx sequence 0,1,2,...,7,0 with one GAP cycle between grants.
REQ-028 ptr=6 (last grant was 5), req=8'h21 -> grant_idx=0 (wrap search 6,7,0), not 5.
REQ-029 With ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h04 held and no done -> grant lasts exactly 4 cycles, timeout_pulse=1 on the last one, then GAP, then regrant to 2. Without the macro -> the grant holds indefinitely and timeout_pulse stays 0.
REQ-030 sys_rst pulsed at cycle 3 of a grant to index 3 -> grant_valid=0 and grant_oh=0 asynchronously; after release, req=8'h18 -> grant_idx=3 (ptr back to 0).
REQ-031 Granted idx=1 and done=8'h04 (non-granted bit) -> the grant continues; req[1] dropped -> the grant ends and GAP follows.
